// File: rtl/frame_packer.sv
// rtl/frame_packer.sv - buffers packed words in a FIFO and emits fixed-length frames on a stream port
// Optional per-frame header word: define FRAME_PACKER_HDR_EN.
module frame_packer #(
  parameter int unsigned FIFO_DEPTH  = 32,
  parameter logic [31:0] FRAME_MAGIC = 32'hFA1D_0001
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [127:0]                 packed_data,
  input  logic                         packed_data_valid,
  input  logic [7:0]                   frame_words,
  output logic [127:0]                 m_tdata,
  output logic                         m_tvalid,
  output logic                         m_tlast,
  input  logic                         m_tready,
  output logic [15:0]                  overflow_cnt,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_e;

  state_e          state_q;
  logic [127:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q, rd_next;
  logic [LW-1:0]   level_q, level_d;
  logic [LW-1:0]   frame_len_q, cnt_q, clen;
  logic [31:0]     seq_q;
  logic [15:0]     ovf_q;
  logic [127:0]    tdata_q;
  logic            tvalid_q, tlast_q;
  logic            push, pop, start_ok;

`ifdef FRAME_PACKER_HDR_EN
  function automatic logic [127:0] hdr_word(input logic [31:0] seq, input logic [15:0] ovf,
                                            input logic [LW-1:0] len);
    return {FRAME_MAGIC, seq, 16'h0, ovf, 24'h0, 8'(len)};
  endfunction
`endif

  always_comb begin
    clen = LW'(FIFO_DEPTH);
    if (frame_words == 8'd0)
      clen = LW'(1);
    else if (32'(frame_words) <= FIFO_DEPTH)
      clen = LW'(frame_words);
  end

  assign rd_next = rd_ptr_q + AW'(1);
  assign pop     = tvalid_q && m_tready && (state_q == DATA);
  assign push    = packed_data_valid && ((level_q < LW'(FIFO_DEPTH)) || pop);

  always_comb begin
    level_d = level_q;
    if (push && !pop)
      level_d = level_q + LW'(1);
    else if (pop && !push)
      level_d = level_q - LW'(1);
  end

  // A new frame may only begin once every one of its words is already stored,
  // which is why the back-to-back case ignores a word arriving this cycle.
  assign start_ok = (state_q == IDLE) ? (level_q >= clen)
                                      : (pop && tlast_q && ((level_q - LW'(1)) >= clen));

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= packed_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ovf_q       <= '0;
      seq_q       <= '0;
      frame_len_q <= LW'(1);
      cnt_q       <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      level_q <= level_d;
      if (push)
        wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)
        rd_ptr_q <= rd_next;
      if (packed_data_valid && !push && (ovf_q != 16'hFFFF))
        ovf_q <= ovf_q + 16'd1;
      if (pop && tlast_q)
        seq_q <= seq_q + 32'd1;

      if (start_ok) begin
        frame_len_q <= clen;
        tvalid_q    <= 1'b1;
`ifdef FRAME_PACKER_HDR_EN
        state_q <= HDR;
        tdata_q <= hdr_word((state_q == DATA) ? seq_q + 32'd1 : seq_q, ovf_q, clen);
        tlast_q <= 1'b0;
`else
        state_q <= DATA;
        tdata_q <= mem_q[(state_q == DATA) ? rd_next : rd_ptr_q];
        tlast_q <= (clen == LW'(1));
        cnt_q   <= LW'(1);
`endif
      end else begin
        case (state_q)
          HDR: if (tvalid_q && m_tready) begin
            state_q <= DATA;
            tdata_q <= mem_q[rd_ptr_q];
            tlast_q <= (frame_len_q == LW'(1));
            cnt_q   <= LW'(1);
          end
          DATA: if (pop) begin
            if (tlast_q) begin
              state_q  <= IDLE;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              tdata_q  <= '0;
            end else begin
              tdata_q <= mem_q[rd_next];
              tlast_q <= ((cnt_q + LW'(1)) == frame_len_q);
              cnt_q   <= cnt_q + LW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign m_tdata      = tdata_q;
  assign m_tvalid     = tvalid_q;
  assign m_tlast      = tlast_q;
  assign overflow_cnt = ovf_q;
  assign fifo_level   = level_q;

endmodule

// File: tb/tb_frame_packer.sv
// tb/tb_frame_packer.sv - scoreboard bench for frame_packer (header checks under FRAME_PACKER_HDR_EN)
module tb_frame_packer;
  localparam int DEPTH = 32;
  localparam logic [31:0] MAGIC = 32'hFA1D_0001;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] packed_data;
  logic         packed_data_valid;
  logic [7:0]   frame_words;
  logic [127:0] m_tdata;
  logic         m_tvalid, m_tlast, m_tready;
  logic [15:0]  overflow_cnt;
  logic [5:0]   fifo_level;

  frame_packer #(.FIFO_DEPTH(DEPTH), .FRAME_MAGIC(MAGIC)) dut (
    .clk(clk), .rst_n(rst_n), .packed_data(packed_data), .packed_data_valid(packed_data_valid),
    .frame_words(frame_words), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .overflow_cnt(overflow_cnt), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int ready_mode = 0;
  int cyc = 0;
  int model_ovf = 0;
  logic [127:0] exp_data[$];
  int exp_len[$];
  int exp_ovf[$];

  bit in_frame = 0, gap_armed = 0, prev_stall = 0;
  int cur_len = 0, cur_ovf = 0, data_idx = 0, last_end = 0, last_gap = -1;
  logic [31:0] exp_seq = 0;
  logic [127:0] prev_data;
  logic prev_last;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic on_handshake();
    bit is_hdr = 0;
    if (!in_frame) begin
      if (exp_len.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_frame: got word %0h expected no frame", m_tdata);
        return;
      end
      cur_len  = exp_len.pop_front();
      cur_ovf  = exp_ovf.pop_front();
      in_frame = 1;
      data_idx = 0;
`ifdef FRAME_PACKER_HDR_EN
      is_hdr = 1;
      chk("hdr_word", m_tdata, {MAGIC, exp_seq, 16'h0, 16'(cur_ovf), 24'h0, 8'(cur_len)});
      chk("hdr_tlast", m_tlast, 1'b0);
`endif
    end
    if (!is_hdr) begin
      if (exp_data.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_data: got %0h expected none", m_tdata);
      end else begin
        chk("data", m_tdata, exp_data.pop_front());
      end
      chk("tlast", m_tlast, (data_idx == cur_len - 1));
      data_idx++;
      if (data_idx == cur_len) begin
        in_frame  = 0;
        exp_seq   = exp_seq + 32'd1;
        gap_armed = 1;
        last_end  = cyc;
      end
    end
  endtask

  // Monitor: samples on the falling edge, a handshake seen here completes at the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        in_frame = 0; gap_armed = 0; prev_stall = 0; exp_seq = 0;
        exp_data.delete(); exp_len.delete(); exp_ovf.delete();
      end else begin
        if (prev_stall) begin
          chk("hold_valid", m_tvalid, 1'b1);
          chk("hold_data", m_tdata, prev_data);
          chk("hold_last", m_tlast, prev_last);
        end
        if (in_frame) chk("valid_mid_frame", m_tvalid, 1'b1);
        if (!in_frame && m_tvalid && gap_armed) begin
          last_gap  = cyc - last_end;
          gap_armed = 0;
        end
        if (m_tvalid && m_tready) on_handshake();
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
      end
    end
  end

  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: m_tready = 1'b1;
        1: m_tready = 1'b0;
        2: m_tready = !m_tready;
        default: m_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  function automatic logic [127:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_word(logic [127:0] w, bit accept);
    packed_data = w;
    packed_data_valid = 1'b1;
    if (accept) exp_data.push_back(w);
    tick(1);
    packed_data_valid = 1'b0;
  endtask

  task automatic add_frames(int n, int len, int ovf);
    for (int i = 0; i < n; i++) begin
      exp_len.push_back(len);
      exp_ovf.push_back(ovf);
    end
  endtask

  task automatic wait_drain(string name);
    int n = 0;
    while ((exp_data.size() != 0 || exp_len.size() != 0 || in_frame) && n < 4000) begin
      tick(1);
      n++;
    end
    chk(name, exp_data.size() + exp_len.size(), 0);
    tick(2);
    chk({name, "_level"}, fifo_level, 0);
  endtask

  task automatic check_reset_outputs(string name);
    chk({name, "_tvalid"}, m_tvalid, 1'b0);
    chk({name, "_tlast"}, m_tlast, 1'b0);
    chk({name, "_tdata"}, m_tdata, 128'h0);
    chk({name, "_level"}, fifo_level, 0);
    chk({name, "_ovf"}, overflow_cnt, 0);
  endtask

  initial begin
    int fw, cl, k;
    rst_n = 1'b0;
    packed_data = '0;
    packed_data_valid = 1'b0;
    frame_words = 8'd5;
    ready_mode = 0;
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Single frame of five words with ready held high.
    add_frames(1, 5, model_ovf);
    for (int i = 0; i < 5; i++) push_word(128'hD0 + 128'(i), 1);
    wait_drain("basic_frame");

    // Ready toggling every cycle across two frames.
    ready_mode = 2;
    add_frames(2, 5, model_ovf);
    for (int i = 0; i < 10; i++) push_word(rand_word(), 1);
    wait_drain("toggle_ready");

    // Ten words buffered first, then released: frames must be back to back.
    ready_mode = 1;
    last_gap = -1;
    add_frames(2, 5, model_ovf);
    for (int i = 0; i < 10; i++) push_word(rand_word(), 1);
    tick(4);
    ready_mode = 0;
    wait_drain("back_to_back");
    chk("b2b_gap", last_gap, 1);

    // Length change while a frame is in flight, then zero-length requests.
    add_frames(1, 5, model_ovf);
    for (int i = 0; i < 5; i++) push_word(rand_word(), 1);
    for (int n = 0; n < 200 && !(in_frame && data_idx >= 1); n++) tick(1);
    chk("midframe_reached", in_frame, 1'b1);
    frame_words = 8'd2;
    add_frames(1, 2, model_ovf);
    for (int i = 0; i < 2; i++) push_word(rand_word(), 1);
    wait_drain("len_change");
    frame_words = 8'd0;
    add_frames(3, 1, model_ovf);
    for (int i = 0; i < 3; i++) push_word(rand_word(), 1);
    wait_drain("len_zero");

    // Overflow: 40 words into a stalled 32-deep FIFO, frames of 8.
    ready_mode = 1;
    frame_words = 8'd8;
    add_frames(1, 8, model_ovf);
    add_frames(3, 8, model_ovf + 8);
    for (int i = 0; i < 40; i++) push_word(rand_word(), i < DEPTH);
    tick(1);
    chk("ovf_level", fifo_level, DEPTH);
    chk("ovf_count", overflow_cnt, model_ovf + 8);
    model_ovf += 8;
    ready_mode = 0;
    wait_drain("overflow");

    // Reset pulse in the middle of a frame.
    ready_mode = 2;
    frame_words = 8'd5;
    add_frames(1, 5, model_ovf);
    for (int i = 0; i < 5; i++) push_word(rand_word(), 1);
    tick(4);
    rst_n = 1'b0;
    tick(1);
    check_reset_outputs("midframe_reset");
    rst_n = 1'b1;
    model_ovf = 0;
    ready_mode = 0;
    add_frames(1, 5, model_ovf);
    for (int i = 0; i < 5; i++) push_word(rand_word(), 1);
    wait_drain("after_reset");

    // Random bursts: each burst is a whole number of frames that fits in the FIFO.
    for (int b = 0; b < 14; b++) begin
      case ($urandom_range(0, 9))
        0: fw = 0;
        1: fw = 200;
        default: fw = $urandom_range(1, 12);
      endcase
      cl = (fw == 0) ? 1 : ((fw > DEPTH) ? DEPTH : fw);
      k = $urandom_range(1, DEPTH / cl);
      frame_words = 8'(fw);
      ready_mode = ($urandom_range(0, 3) == 0) ? 2 : 3;
      add_frames(k, cl, model_ovf);
      for (int i = 0; i < k * cl; i++) begin
        if ($urandom_range(0, 2) == 0) tick(1);
        push_word(rand_word(), 1);
      end
      wait_drain("random_burst");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_packer.md
FRAME_PACKER -- requirements
Module: frame_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 32, sets the data FIFO depth in 128-bit words; it is a power of two and at least 4.
REQ-002 Parameter FRAME_MAGIC, default 32'hFA1D_0001, is the frame header sync word.
REQ-003 clk  input  1  is the single clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  is the reset: synchronous, active-low.
REQ-005 packed_data  input  128  carries data words from the upstream packing stage.
REQ-006 packed_data_valid  input  1  is a one-cycle-per-word strobe; there is no backpressure to upstream.
REQ-007 frame_words  input  8  is the number of data words per frame; 0 is treated as 1; values above FIFO_DEPTH are clamped to FIFO_DEPTH.
REQ-008 m_tdata  output  128  is the stream data.
REQ-009 m_tvalid  output  1  is the stream valid.
REQ-010 m_tlast  output  1  marks the last word of a frame.
REQ-011 m_tready  input  1  is the downstream ready.
REQ-012 overflow_cnt  output  16  counts dropped input words and saturates at 16'hFFFF.
REQ-013 fifo_level  output  $clog2(FIFO_DEPTH)+1  is the current FIFO occupancy.

Function
REQ-014 A word is accepted into the FIFO when packed_data_valid=1 and either (fifo_level<FIFO_DEPTH) or a pop occurs in the same cycle.
REQ-015 A word that is not accepted is dropped and increments overflow_cnt by 1, saturating at the maximum.
REQ-016 A pop occurs exactly when m_tvalid=1, m_tready=1 and the current word is a data word (not a header).
REQ-017 The FSM has three states: IDLE, HDR and DATA.
REQ-018 In IDLE, when fifo_level >= the clamped frame length, the FSM latches frame_len and moves to HDR (or to DATA per REQ-026); m_tvalid rises on the next cycle.
REQ-019 frame_len is latched only on the IDLE exit; changes to frame_words mid-frame do not affect the frame in progress.
REQ-020 In HDR, m_tdata = {FRAME_MAGIC, seq_num[31:0], 16'h0, overflow_cnt snapshot taken at IDLE exit, 24'h0, frame_len[7:0]} and m_tlast=0; the FSM moves to DATA on handshake.
REQ-021 In DATA, m_tdata presents the FIFO head word (first-word fall-through); m_tlast=1 only on the frame_len-th data word.
REQ-022 On the handshake of the last data word, seq_num increments by 1 (wrapping from 32'hFFFF_FFFF to 0); the FSM returns to IDLE, or goes directly to HDR/DATA if a full frame is already buffered, with no bubble cycle.
REQ-023 While m_tvalid=1 and m_tready=0, m_tdata and m_tlast are held stable; m_tvalid never deasserts mid-frame.
REQ-024 A frame only starts when it is fully buffered, so the FIFO never underflows mid-frame.
REQ-025 fifo_level updates one cycle after push/pop; a simultaneous push and pop leaves it unchanged.

Configuration
REQ-026 With the macro FRAME_PACKER_HDR_EN defined, each frame is one header word followed by frame_len data words; without it, the HDR state is never entered, frames are data words only, and seq_num remains internal.

Reset
REQ-027 While rst_n=0 at a clock edge: FSM=IDLE, the FIFO is emptied, fifo_level=0, m_tvalid=0, m_tlast=0, m_tdata=0, overflow_cnt=0, seq_num=0, frame_len=1.
REQ-028 A reset asserted mid-frame discards the partial frame; the first frame after reset carries seq_num=0.

Verification
REQ-029 HDR_EN defined, frame_words=5, 5 words D0..D4, m_tready=1 -> header (magic FA1D_0001, seq 0, len 5), then D0..D4, tlast only on D4.
REQ-030 m_tready toggling 1/0 every cycle during a frame -> each word is held stable while ready=0, no word is lost or duplicated, and the second frame carries seq=1.
REQ-031 FIFO_DEPTH=32, m_tready=0, 40 consecutive valid words -> fifo_level=32, overflow_cnt=8, and the next header's overflow field is 8.
REQ-032 With 10 buffered words and frame_words=5, ready=1 -> two frames back-to-back with no idle cycle between tlast and the next header.
REQ-033 frame_words changed from 5 to 2 during DATA -> the current frame keeps length 5 and the next frame has length 2; frame_words=0 -> frames of 1 word.
REQ-034 rst_n pulsed low for 1 cycle mid-frame -> all outputs return to zero next cycle, and the following frame carries seq 0.
